// File: rtl/stopwatch_pkg.sv
// Shared definitions for the lap stopwatch: BCD digit width, digit moduli,
// the BCD digit type and a helper that maps a digit position to its modulus.
package stopwatch_pkg;

    localparam int DIGIT_W = 4;   // bits per BCD digit
    localparam int DEC_MOD = 10;  // decimal digit modulus
    localparam int SEX_MOD = 6;   // tens-of-seconds digit modulus

    // Digit position of the tens-of-seconds digit, counting from CENTISEC = 0.
    localparam int TENSEC_IDX = 3;

    typedef logic [DIGIT_W-1:0] bcd_t;

    // Digit order, least significant first:
    //   0 CENTISEC, 1 DECISEC, 2 SEC, 3 TENSEC, 4.. MIN digits.
    function automatic int digit_modulus(input int idx);
        return (idx == TENSEC_IDX) ? SEX_MOD : DEC_MOD;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the stopwatch: a modulus-parameterised up/down counter.
// en_i advances the digit by one step in the direction given by down_i;
// carry_o is asserted combinationally when that step rolls the digit over
// (TOP->0 counting up, 0->TOP counting down), so digits chain by feeding
// carry_o into the next digit's en_i and the ripple completes in one edge.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int MODULUS = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic down_i,
    output bcd_t digit_o,
    output logic carry_o
);

    localparam bcd_t TOP = bcd_t'(MODULUS - 1);

    bcd_t digit_q;
    bcd_t digit_d;

    // Next digit value and rollover flag for this cycle's step.
    always_comb begin
        digit_d = digit_q;
        carry_o = 1'b0;
        if (en_i) begin
            if (down_i) begin
                if (digit_q == '0) begin
                    digit_d = TOP;
                    carry_o = 1'b1;
                end else begin
                    digit_d = digit_q - bcd_t'(1);
                end
            end else begin
                // >= keeps an out-of-range value from ever propagating.
                if (digit_q >= TOP) begin
                    digit_d = '0;
                    carry_o = 1'b1;
                end else begin
                    digit_d = digit_q + bcd_t'(1);
                end
            end
        end
    end

    // Digit register with synchronous reset to zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;

endmodule

// File: rtl/lap_stopwatch.sv
// Lap stopwatch: BCD centisecond timer {MIN.., TENSEC, SEC, DECISEC, CENTISEC}
// that counts up or down on a prescaled tick, flags rollover with WRAP and,
// when built with STOPWATCH_LAP_EN defined, captures TIME into LAP_TIME on LAP.
// Without STOPWATCH_LAP_EN the lap registers are absent, LAP is ignored and
// LAP_TIME/LAP_VALID are tied to zero.
module lap_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int MIN_DIGITS = 1,
    parameter int TICK_DIV   = 1
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        ENABLE,
    input  logic                        DOWN,
    input  logic                        LAP,
    output logic [16+4*MIN_DIGITS-1:0]  TIME,
    output logic [16+4*MIN_DIGITS-1:0]  LAP_TIME,
    output logic                        LAP_VALID,
    output logic                        WRAP
);

    localparam int NDIG = 4 + MIN_DIGITS;
    localparam int TW   = NDIG * DIGIT_W;
    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    // ------------------------------------------------------------------
    // Prescaler: counts 0..TICK_DIV-1 while enabled, frozen while held.
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick;

    // Tick on the last prescaler count of an enabled cycle.
    always_comb begin
        tick    = ENABLE && (presc_q == PRESC_LAST);
        presc_d = presc_q;
        if (ENABLE) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // ------------------------------------------------------------------
    // Digit chain: CENTISEC is stepped by tick, each higher digit by the
    // rollover of the one below. DOWN only matters when a step happens,
    // so a change between ticks naturally applies from the next tick.
    // ------------------------------------------------------------------
    logic [NDIG:0]   step_en;
    bcd_t            digits [NDIG];
    logic [TW-1:0]   time_w;

    assign step_en[0] = tick;

    for (genvar i = 0; i < NDIG; i++) begin : g_digit
        bcd_digit #(
            .MODULUS (digit_modulus(i))
        ) u_digit (
            .clk_i   (CLK),
            .rst_i   (RESET),
            .en_i    (step_en[i]),
            .down_i  (DOWN),
            .digit_o (digits[i]),
            .carry_o (step_en[i+1])
        );
        assign time_w[i*DIGIT_W +: DIGIT_W] = digits[i];
    end

    assign TIME = time_w;

    // ------------------------------------------------------------------
    // WRAP: the top digit rolling over means the whole display went
    // max->0 or 0->max on this tick; registered so it aligns with TIME.
    // ------------------------------------------------------------------
    logic wrap_q;

    // Rollover pulse register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= step_en[NDIG];
        end
    end

    assign WRAP = wrap_q;

    // ------------------------------------------------------------------
    // Lap capture: grabs the TIME value visible before the LAP edge,
    // independent of ENABLE; reset wins over a simultaneous LAP.
    // ------------------------------------------------------------------
`ifdef STOPWATCH_LAP_EN
    logic [TW-1:0] lap_time_q;
    logic [TW-1:0] lap_time_d;
    logic          lap_valid_q;
    logic          lap_valid_d;

    // Next lap value and one-cycle valid pulse.
    always_comb begin
        lap_time_d  = lap_time_q;
        lap_valid_d = 1'b0;
        if (LAP) begin
            lap_time_d  = time_w;
            lap_valid_d = 1'b1;
        end
    end

    // Lap registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            lap_time_q  <= '0;
            lap_valid_q <= 1'b0;
        end else begin
            lap_time_q  <= lap_time_d;
            lap_valid_q <= lap_valid_d;
        end
    end

    assign LAP_TIME  = lap_time_q;
    assign LAP_VALID = lap_valid_q;
`else
    // LAP has no function in this build.
    logic unused_lap;
    assign unused_lap = LAP;

    assign LAP_TIME  = '0;
    assign LAP_VALID = 1'b0;
`endif

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: two instances (TICK_DIV=1 and TICK_DIV=4,
// MIN_DIGITS=1) share one stimulus stream; an integer-centisecond reference
// model produces expected outputs that are queued per step and compared
// after the edge, plus directed value checks at the key scenario points.
module tb_lap_stopwatch;

    localparam int TW   = 20;
    localparam int MAXT = 59999;          // 9:59:99 in centiseconds
    localparam int EW   = 2 * TW + 2;     // {time, lap_time, lap_valid, wrap}

    logic CLK    = 1'b0;
    logic RESET  = 1'b1;
    logic ENABLE = 1'b0;
    logic DOWN   = 1'b0;
    logic LAP    = 1'b0;

    logic [TW-1:0] time1, lap_time1, time4, lap_time4;
    logic          lap_valid1, wrap1, lap_valid4, wrap4;

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    lap_stopwatch #(.MIN_DIGITS(1), .TICK_DIV(1)) dut1 (
        .CLK       (CLK),
        .RESET     (RESET),
        .ENABLE    (ENABLE),
        .DOWN      (DOWN),
        .LAP       (LAP),
        .TIME      (time1),
        .LAP_TIME  (lap_time1),
        .LAP_VALID (lap_valid1),
        .WRAP      (wrap1)
    );

    lap_stopwatch #(.MIN_DIGITS(1), .TICK_DIV(4)) dut4 (
        .CLK       (CLK),
        .RESET     (RESET),
        .ENABLE    (ENABLE),
        .DOWN      (DOWN),
        .LAP       (LAP),
        .TIME      (time4),
        .LAP_TIME  (lap_time4),
        .LAP_VALID (lap_valid4),
        .WRAP      (wrap4)
    );

    // ---------------- scoreboard / model ----------------
    int checks = 0;
    int passed = 0;
    logic [EW-1:0] exp_q[$];

    int            m_t  [2] = '{0, 0};
    int            m_p  [2] = '{0, 0};
    int            m_div[2] = '{1, 4};
    logic          m_w  [2] = '{1'b0, 1'b0};
    logic [TW-1:0] m_lt [2] = '{'0, '0};
    logic          m_lv [2] = '{1'b0, 1'b0};

    function automatic logic [TW-1:0] to_bcd(input int t);
        int mn, rem, sec, cs;
        mn  = t / 6000;
        rem = t % 6000;
        sec = rem / 100;
        cs  = rem % 100;
        return {4'(mn % 10), 4'(sec / 10), 4'(sec % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    // Advance reference model k by one clock edge with the current inputs.
    task automatic model_edge(input int k);
        logic tk;
        if (RESET) begin
            m_t[k] = 0; m_p[k] = 0; m_w[k] = 1'b0; m_lt[k] = '0; m_lv[k] = 1'b0;
        end else begin
`ifdef STOPWATCH_LAP_EN
            if (LAP) begin
                m_lt[k] = to_bcd(m_t[k]);
                m_lv[k] = 1'b1;
            end else begin
                m_lv[k] = 1'b0;
            end
`else
            m_lt[k] = '0;
            m_lv[k] = 1'b0;
`endif
            m_w[k] = 1'b0;
            if (ENABLE) begin
                tk = (m_p[k] == m_div[k] - 1);
                m_p[k] = tk ? 0 : m_p[k] + 1;
                if (tk) begin
                    if (!DOWN) begin
                        if (m_t[k] == MAXT) begin m_t[k] = 0; m_w[k] = 1'b1; end
                        else m_t[k] = m_t[k] + 1;
                    end else begin
                        if (m_t[k] == 0) begin m_t[k] = MAXT; m_w[k] = 1'b1; end
                        else m_t[k] = m_t[k] - 1;
                    end
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_dut(input string name, input logic [TW-1:0] t, input logic [TW-1:0] lt,
                               input logic lv, input logic w);
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check({name, ".time"},      t,         e[EW-1 -: TW]);
        check({name, ".lap_time"},  lt,        e[TW+1 -: TW]);
        check({name, ".lap_valid"}, TW'(lv),   TW'(e[1]));
        check({name, ".wrap"},      TW'(w),    TW'(e[0]));
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic rst, input logic en, input logic dn, input logic lp);
        RESET = rst; ENABLE = en; DOWN = dn; LAP = lp;
        for (int k = 0; k < 2; k++) begin
            model_edge(k);
            exp_q.push_back({to_bcd(m_t[k]), m_lt[k], m_lv[k], m_w[k]});
        end
        @(posedge CLK);
        #1;
        compare_dut("div1", time1, lap_time1, lap_valid1, wrap1);
        compare_dut("div4", time4, lap_time4, lap_valid4, wrap4);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset state.
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("reset.time", time1, 20'h00000);
        check("reset.lap_valid", TW'(lap_valid1), '0);

        // Run up 200 cycles.
        repeat (200) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("run200.time", time1, 20'h00200);
        check("run200.div4", time4, 20'h00050);

        // Lap at 0:01:23.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (123) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("lap.pre", time1, 20'h00123);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("lap.time_after", time1, 20'h00124);
`ifdef STOPWATCH_LAP_EN
        check("lap.lap_time", lap_time1, 20'h00123);
        check("lap.valid", TW'(lap_valid1), TW'(1));
`else
        check("lap.lap_time_off", lap_time1, 20'h00000);
        check("lap.valid_off", TW'(lap_valid1), '0);
`endif
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("lap.valid_drop", TW'(lap_valid1), '0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);   // held LAP while paused
        step(1'b1, 1'b1, 1'b0, 1'b1);              // LAP with RESET
        check("lap.with_reset", TW'(lap_valid1), '0);
        check("lap.with_reset_time", time1, 20'h00000);

        // Down from zero wraps to max, then up rolls back over.
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("down.wrap_time", time1, 20'h95999);
        check("down.wrap_flag", TW'(wrap1), TW'(1));
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("down.wrap_once", TW'(wrap1), '0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("up.max", time1, 20'h95999);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("up.rollover", time1, 20'h00000);
        check("up.wrap_flag", TW'(wrap1), TW'(1));
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("up.wrap_once", TW'(wrap1), '0);

        // Up to 1:00:00, then one tick down.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (6000) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("up.one_min", time1, 20'h10000);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("down.borrow", time1, 20'h05999);

        // Prescaler: 40 enabled, 7 held, 4 enabled.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (40) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("presc.run40", time4, 20'h00010);
        repeat (7) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("presc.hold", time4, 20'h00010);
        check("presc.hold_wrap", TW'(wrap4), '0);
        repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("presc.resume", time4, 20'h00011);

        // Random mix: DOWN toggling between ticks, pauses, laps, rare resets.
        repeat (400) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
